// File: rtl/sgd_dot_accum.sv
// Accumulates NUM_CHUNKS signed partial sums per dot product and queues each
// completed result in a 2-entry output FIFO with ready/valid handshake.
module sgd_dot_accum #(
  parameter int NUM_CHUNKS = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 48
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic signed [DATA_WIDTH-1:0] v_input,
  input  logic                         v_input_valid,
  output logic signed [ACC_WIDTH-1:0]  dot_out,
  output logic                         dot_out_valid,
  input  logic                         dot_out_ready,
  output logic [31:0]                  sample_cnt,
  output logic                         overflow
);

  localparam int CNT_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

  function automatic logic signed [ACC_WIDTH-1:0] sext(input logic signed [DATA_WIDTH-1:0] v);
    sext = ACC_WIDTH'(v);
  endfunction

  logic signed [ACC_WIDTH-1:0] acc_p0;
  logic [CNT_W-1:0]            chunk_cnt_p0;
  logic signed [ACC_WIDTH-1:0] ext_p0;
  logic signed [ACC_WIDTH-1:0] sum_p0;
  logic                        vld_p0;
  logic                        final_p0;

  // Stage p0: accumulate incoming partial sums; a beat during clear is dropped.
  assign vld_p0   = v_input_valid && !clear;
  assign final_p0 = vld_p0 && (chunk_cnt_p0 == LAST_CHUNK);
  assign ext_p0   = sext(v_input);
  assign sum_p0   = (chunk_cnt_p0 == '0) ? ext_p0 : acc_p0 + ext_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_p0       <= '0;
      chunk_cnt_p0 <= '0;
    end else if (clear) begin
      acc_p0       <= '0;
      chunk_cnt_p0 <= '0;
    end else if (vld_p0) begin
      acc_p0       <= sum_p0;
      chunk_cnt_p0 <= final_p0 ? '0 : chunk_cnt_p0 + 1'b1;
    end
  end

  logic signed [ACC_WIDTH-1:0] mem_p1 [2];
  logic       rd_ptr_p1;
  logic       wr_ptr_p1;
  logic [1:0] count_p1;
  logic       pop_p1;
  logic       full_p1;
  logic       push_p1;

  // Stage p1: output FIFO; a push into a full FIFO still succeeds if a pop frees a slot.
  assign pop_p1  = (count_p1 != 2'd0) && dot_out_ready;
  assign full_p1 = (count_p1 == 2'd2);
  assign push_p1 = final_p0 && (!full_p1 || pop_p1);

  always_ff @(posedge clk) begin
    if (push_p1 && !clear) mem_p1[wr_ptr_p1] <= sum_p0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_p1  <= 1'b0;
      wr_ptr_p1  <= 1'b0;
      count_p1   <= 2'd0;
      sample_cnt <= 32'd0;
      overflow   <= 1'b0;
    end else if (clear) begin
      rd_ptr_p1  <= 1'b0;
      wr_ptr_p1  <= 1'b0;
      count_p1   <= 2'd0;
      sample_cnt <= 32'd0;
      overflow   <= 1'b0;
    end else begin
      if (push_p1) begin
        wr_ptr_p1  <= ~wr_ptr_p1;
        sample_cnt <= sample_cnt + 32'd1;
      end
      if (pop_p1) rd_ptr_p1 <= ~rd_ptr_p1;
      if (final_p0 && full_p1 && !pop_p1) overflow <= 1'b1;
      case ({push_p1, pop_p1})
        2'b10:   count_p1 <= count_p1 + 2'd1;
        2'b01:   count_p1 <= count_p1 - 2'd1;
        default: count_p1 <= count_p1;
      endcase
    end
  end

  assign dot_out_valid = (count_p1 != 2'd0);
  assign dot_out       = dot_out_valid ? mem_p1[rd_ptr_p1] : '0;

endmodule

// File: tb/tb_sgd_dot_accum.sv
// Directed bench for sgd_dot_accum (NUM_CHUNKS=4, DATA_WIDTH=32, ACC_WIDTH=48).
module tb_sgd_dot_accum;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               clear = 1'b0;
  logic signed [31:0] v_input = '0;
  logic               v_input_valid = 1'b0;
  logic signed [47:0] dot_out;
  logic               dot_out_valid;
  logic               dot_out_ready = 1'b1;
  logic [31:0]        sample_cnt;
  logic               overflow;

  int compared = 0;
  int mismatched = 0;

  sgd_dot_accum #(.NUM_CHUNKS(4), .DATA_WIDTH(32), .ACC_WIDTH(48)) dut (
    .clk(clk), .rst(rst), .clear(clear), .v_input(v_input),
    .v_input_valid(v_input_valid), .dot_out(dot_out), .dot_out_valid(dot_out_valid),
    .dot_out_ready(dot_out_ready), .sample_cnt(sample_cnt), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic beat(input logic signed [31:0] v);
    v_input = v;
    v_input_valid = 1'b1;
    @(posedge clk); #1;
    v_input_valid = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    compared++; if (dot_out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %0b want 0", dot_out_valid); end
    compared++; if (dot_out !== 48'sd0) begin mismatched++; $display("FAIL reset_dot: got %0h want 0", dot_out); end
    compared++; if (sample_cnt !== 32'd0) begin mismatched++; $display("FAIL reset_cnt: got %0d want 0", sample_cnt); end
    compared++; if (overflow !== 1'b0) begin mismatched++; $display("FAIL reset_ovf: got %0b want 0", overflow); end
    @(posedge clk); #1;
    rst = 1'b0;
    idle();
  endtask

  task automatic test_basic();
    dot_out_ready = 1'b1;
    beat(36); beat(36); beat(36);
    compared++; if (dot_out_valid !== 1'b0) begin mismatched++; $display("FAIL basic_partial: valid got %0b want 0", dot_out_valid); end
    beat(36);
    compared++; if (dot_out_valid !== 1'b1) begin mismatched++; $display("FAIL basic_valid: got %0b want 1", dot_out_valid); end
    compared++; if (dot_out !== 48'sd144) begin mismatched++; $display("FAIL basic_dot: got %0d want 144", dot_out); end
    compared++; if (sample_cnt !== 32'd1) begin mismatched++; $display("FAIL basic_cnt: got %0d want 1", sample_cnt); end
    idle();
    compared++; if (dot_out_valid !== 1'b0) begin mismatched++; $display("FAIL basic_one_cycle: valid got %0b want 0", dot_out_valid); end
    compared++; if (dot_out !== 48'sd0) begin mismatched++; $display("FAIL basic_empty_dot: got %0h want 0", dot_out); end
  endtask

  task automatic test_sign();
    beat(-5); beat(3); beat(-10); beat(2);
    compared++; if (dot_out_valid !== 1'b1) begin mismatched++; $display("FAIL sign_valid: got %0b want 1", dot_out_valid); end
    compared++; if (dot_out !== 48'hFFFF_FFFF_FFF6) begin mismatched++; $display("FAIL sign_dot: got %0h want fffffffffff6", dot_out); end
    idle();
  endtask

  task automatic test_overflow();
    do_clear();
    dot_out_ready = 1'b0;
    beat(1); beat(0); beat(0); beat(0);
    beat(2); beat(0); beat(0); beat(0);
    compared++; if (overflow !== 1'b0) begin mismatched++; $display("FAIL ovf_early: got %0b want 0", overflow); end
    beat(3); beat(0); beat(0); beat(0);
    compared++; if (overflow !== 1'b1) begin mismatched++; $display("FAIL ovf_flag: got %0b want 1", overflow); end
    compared++; if (sample_cnt !== 32'd2) begin mismatched++; $display("FAIL ovf_cnt: got %0d want 2", sample_cnt); end
    idle();
    compared++; if (dot_out_valid !== 1'b1 || dot_out !== 48'sd1) begin mismatched++; $display("FAIL ovf_hold: got %0b/%0d want 1/1", dot_out_valid, dot_out); end
    dot_out_ready = 1'b1;
    idle();
    compared++; if (dot_out_valid !== 1'b1 || dot_out !== 48'sd2) begin mismatched++; $display("FAIL ovf_second: got %0b/%0d want 1/2", dot_out_valid, dot_out); end
    idle();
    compared++; if (dot_out_valid !== 1'b0) begin mismatched++; $display("FAIL ovf_drain: valid got %0b want 0", dot_out_valid); end
    compared++; if (overflow !== 1'b1) begin mismatched++; $display("FAIL ovf_sticky: got %0b want 1", overflow); end
  endtask

  task automatic test_full_pop();
    do_clear();
    dot_out_ready = 1'b0;
    beat(10); beat(0); beat(0); beat(0);
    beat(20); beat(0); beat(0);
    beat(0);
    beat(30); beat(0); beat(0);
    dot_out_ready = 1'b1;
    beat(0);
    compared++; if (overflow !== 1'b0) begin mismatched++; $display("FAIL fullpop_ovf: got %0b want 0", overflow); end
    compared++; if (sample_cnt !== 32'd3) begin mismatched++; $display("FAIL fullpop_cnt: got %0d want 3", sample_cnt); end
    compared++; if (dot_out !== 48'sd20) begin mismatched++; $display("FAIL fullpop_head: got %0d want 20", dot_out); end
    idle();
    compared++; if (dot_out_valid !== 1'b1 || dot_out !== 48'sd30) begin mismatched++; $display("FAIL fullpop_new: got %0b/%0d want 1/30", dot_out_valid, dot_out); end
    idle();
    compared++; if (dot_out_valid !== 1'b0) begin mismatched++; $display("FAIL fullpop_drain: valid got %0b want 0", dot_out_valid); end
  endtask

  task automatic test_clear();
    dot_out_ready = 1'b1;
    beat(7); beat(7);
    v_input = 7; v_input_valid = 1'b1; clear = 1'b1;
    @(posedge clk); #1;
    v_input_valid = 1'b0; clear = 1'b0;
    compared++; if (sample_cnt !== 32'd0) begin mismatched++; $display("FAIL clear_cnt: got %0d want 0", sample_cnt); end
    beat(1); beat(1); beat(1);
    compared++; if (dot_out_valid !== 1'b0) begin mismatched++; $display("FAIL clear_partial: valid got %0b want 0", dot_out_valid); end
    beat(1);
    compared++; if (dot_out_valid !== 1'b1 || dot_out !== 48'sd4) begin mismatched++; $display("FAIL clear_dot: got %0b/%0d want 1/4", dot_out_valid, dot_out); end
    idle();
  endtask

  task automatic test_rst_mid();
    beat(5); beat(5); beat(5);
    rst = 1'b1;
    #1;
    compared++; if (dot_out_valid !== 1'b0 || sample_cnt !== 32'd0) begin mismatched++; $display("FAIL rst_async: got %0b/%0d want 0/0", dot_out_valid, sample_cnt); end
    @(posedge clk); #1;
    rst = 1'b0;
    beat(32'sh7FFF_FFFF); beat(32'sh7FFF_FFFF); beat(32'sh7FFF_FFFF);
    compared++; if (dot_out_valid !== 1'b0) begin mismatched++; $display("FAIL rst_spurious: valid got %0b want 0", dot_out_valid); end
    beat(32'sh7FFF_FFFF);
    compared++; if (dot_out_valid !== 1'b1 || dot_out !== 48'h1_FFFF_FFFC) begin mismatched++; $display("FAIL rst_dot: got %0b/%0h want 1/1fffffffc", dot_out_valid, dot_out); end
    idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sign();
    test_overflow();
    test_full_pop();
    test_clear();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
